// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants, FSM encoding and address-width helper for the DDS blocks
package dds_pkg;

  localparam int NUM_CH        = 2;
  localparam int DEF_PHASE_W   = 16;
  localparam int DEF_KCOUNT    = 3900;
  localparam int DEF_ROM_WIDTH = 8;
  localparam int DEF_ROM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOK0 = 2'd1,
    LOOK1 = 2'd2
  } state_t;

  // Table holds four quarter-waves worth of addresses.
  function automatic int id_w(input int depth);
    return $clog2(4 * depth);
  endfunction

endpackage

// File: rtl/dds_dual_channel_scheduler_if.sv
// rtl/dds_dual_channel_scheduler_if.sv - per-channel tuning-word configuration handshake
interface dds_dual_channel_scheduler_if #(
  parameter int PHASE_W = 16
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_ch;
  logic [PHASE_W-1:0] cfg_ftw;
  logic               cfg_clr;

  modport master (
    output cfg_valid, cfg_ch, cfg_ftw, cfg_clr,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_ftw, cfg_clr,
    output cfg_ready
  );

endinterface

// File: rtl/dds_tick_gen.sv
// rtl/dds_tick_gen.sv - free-running divider, one-cycle tick every KCOUNT clocks
module dds_tick_gen #(
  parameter int KCOUNT = dds_pkg::DEF_KCOUNT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = $clog2(KCOUNT);
  localparam logic [CW-1:0] LAST = CW'(KCOUNT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dds_dual_channel_scheduler.sv
// rtl/dds_dual_channel_scheduler.sv - two phase accumulators sharing one sine table per sample tick
module dds_dual_channel_scheduler
  import dds_pkg::*;
#(
  parameter int ROM_WIDTH = DEF_ROM_WIDTH,
  parameter int ROM_DEPTH = DEF_ROM_DEPTH,
  parameter int PHASE_W   = DEF_PHASE_W,
  parameter int kCOUNT    = DEF_KCOUNT,
  localparam int ID_W     = id_w(ROM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  dds_dual_channel_scheduler_if.slave cfg,
  output logic [ID_W-1:0]          rom_id,
  input  logic [2*ROM_WIDTH-1:0]   rom_data,
  output logic [2*ROM_WIDTH-1:0]   ch0_data,
  output logic [2*ROM_WIDTH-1:0]   ch1_data,
  output logic                     o_ce
);

  state_t             state, state_next;
  logic               tick;
  logic               xfer;
  logic [PHASE_W-1:0] acc [NUM_CH];
  logic [PHASE_W-1:0] ftw [NUM_CH];
  logic [PHASE_W-1:0] acc0_next;

  dds_tick_gen #(.KCOUNT(kCOUNT)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = LOOK0;
      LOOK0:   state_next = LOOK1;
      LOOK1:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg.cfg_ready = (state == IDLE);
  end

  assign xfer      = cfg.cfg_valid && cfg.cfg_ready;
  assign acc0_next = acc[0] + ftw[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        ftw[i] <= '0;
      end
      rom_id   <= '0;
      ch0_data <= '0;
      ch1_data <= '0;
      o_ce     <= 1'b0;
    end else begin
      o_ce <= (state == LOOK1);
      case (state)
        IDLE: if (tick) begin
          acc[0] <= acc0_next;
          acc[1] <= acc[1] + ftw[1];
          rom_id <= acc0_next[PHASE_W-1 -: ID_W];
        end
        LOOK0: begin
          ch0_data <= rom_data;
          rom_id   <= acc[1][PHASE_W-1 -: ID_W];
        end
        LOOK1:   ch1_data <= rom_data;
        default: ;
      endcase
      // Placed after the tick update so a same-cycle clear wins over accumulation.
      if (xfer) begin
        ftw[cfg.cfg_ch] <= cfg.cfg_ftw;
        if (cfg.cfg_clr) acc[cfg.cfg_ch] <= '0;
      end
    end
  end

endmodule
